// File: rtl/param_counter.sv
// Parametrised up/down counter with runtime terminal value, variable step,
// wrap or saturate mode, parallel load, sync clear, compare match and flags.
module param_counter #(
    parameter int WIDTH    = 64,
    parameter int STEP_W   = 8,
    parameter int SATURATE = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              en,
    input  logic              up,
    input  logic [STEP_W-1:0] step,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_value,
    input  logic [WIDTH-1:0]  limit,
    input  logic [WIDTH-1:0]  cmp_value,
    output logic [WIDTH-1:0]  count,
    output logic              at_limit,
    output logic              at_zero,
    output logic              wrap_pulse,
    output logic              cmp_hit,
    output logic              err
);

    localparam int XW  = WIDTH + 1;
    localparam bit SAT = (SATURATE != 0);

    // One extra bit so limit+1 (range size) and count+step never overflow.
    logic [XW-1:0]    cnt_x, lim_x, range_x, step_x, sum_x;
    logic [WIDTH-1:0] wrap_up, wrap_dn, dn;
    logic [WIDTH-1:0] next_count;
    logic             next_wrap, next_err, next_hit, upd;

    assign cnt_x   = {1'b0, count};
    assign lim_x   = {1'b0, limit};
    assign range_x = lim_x + 1'b1;
    assign step_x  = {{(XW-STEP_W){1'b0}}, step};
    assign sum_x   = cnt_x + step_x;
    assign wrap_up = WIDTH'(sum_x - range_x);
    assign wrap_dn = WIDTH'(cnt_x + range_x - step_x);
    assign dn      = WIDTH'(cnt_x - step_x);

    assign at_limit = (count == limit);
    assign at_zero  = (count == '0);

    always_comb begin
        next_count = count;
        next_wrap  = 1'b0;
        next_err   = err;
        upd        = 1'b0;
        if (clear) begin
            upd        = 1'b1;
            next_count = '0;
            next_err   = 1'b0;
        end else if (load) begin
            upd = 1'b1;
            if (load_value > limit) begin
                next_count = limit;
                next_err   = 1'b1;
            end else begin
                next_count = load_value;
            end
        end else if (en) begin
            upd = 1'b1;
            if (count > limit) begin
                // limit was lowered below the current count: re-enter the range
                next_count = SAT ? limit : '0;
                next_wrap  = !SAT;
            end else if (step_x > range_x) begin
                next_err   = 1'b1;
                next_count = up ? limit : '0;
            end else if (up) begin
                if (sum_x > lim_x) begin
                    next_count = SAT ? limit : wrap_up;
                    next_wrap  = !SAT;
                end else begin
                    next_count = sum_x[WIDTH-1:0];
                end
            end else begin
                if (step_x > cnt_x) begin
                    next_count = SAT ? '0 : wrap_dn;
                    next_wrap  = !SAT;
                end else begin
                    next_count = dn;
                end
            end
        end
        next_hit = upd && (next_count == cmp_value)
                   && ((next_count != count) || next_wrap);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count      <= '0;
            wrap_pulse <= 1'b0;
            cmp_hit    <= 1'b0;
            err        <= 1'b0;
        end else begin
            count      <= next_count;
            wrap_pulse <= next_wrap;
            cmp_hit    <= next_hit;
            err        <= next_err;
        end
    end

endmodule
